// File: rtl/pim_dma_pkg.sv
// Shared types and constants for the PIM buffer -> Hybrid-PIM DMA sequencer.
package pim_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE
  } state_e;

  localparam logic [3:0] PIM_BUF_NIBBLE = 4'h2;
  localparam logic [3:0] PIM_NIBBLE     = 4'h4;
  localparam logic [3:0] SIZE_WORD      = 4'hF;

  // True when the last byte of a span starting at offset 'off' leaves its 256 MB window.
  function automatic logic crosses_window(input logic [27:0] off, input logic [32:0] span);
    return ({5'b0, off} + span - 33'd1) > 33'h0FFF_FFFF;
  endfunction

endpackage

// File: rtl/dma_fifo2.sv
// Two-entry return-data skid FIFO with synchronous flush.
module dma_fifo2 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [31:0] data_i,
  output logic [31:0] head_o,
  output logic [1:0]  count_o
);

  logic [31:0] mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/pim_dma_ctrl.sv
// Copies a block of words from the PIM buffer SRAM (channel 0) to the Hybrid-PIM (channel 1)
// through the shared DMA master port, tolerating grant loss at any cycle.
import pim_dma_pkg::*;

module pim_dma_ctrl #(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             req_dma_o,
  input  logic             gnt_dma_i,
  output logic [31:0]      dma_addr_0_o,
  output logic             dma_read_0_o,
  output logic             dma_write_0_o,
  output logic [3:0]       dma_size_0_o,
  output logic [31:0]      dma_din_0_o,
  input  logic [31:0]      dma_dout_0_i,
  output logic [31:0]      dma_addr_1_o,
  output logic             dma_read_1_o,
  output logic             dma_write_1_o,
  output logic [3:0]       dma_size_1_o,
  output logic [31:0]      dma_din_1_o,
  input  logic [31:0]      dma_dout_1_i
);

  state_e           state_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_cnt_q;
  logic [LEN_W-1:0] wr_cnt_q;
  logic [LEN_W-1:0] wr_cnt_nxt;
  logic             ret_q;

  logic        in_xfer;
  logic        pop;
  logic        rd_issue;
  logic        flush;
  logic        cfg_err;
  logic [2:0]  occ;
  logic [1:0]  fifo_cnt;
  logic [31:0] fifo_head;
  logic [32:0] span;
  logic        unused_dout_1;

  assign unused_dout_1 = ^dma_dout_1_i;

  assign span    = 33'({len_i, 2'b00});
  assign cfg_err = (src_addr_i[31:28] != PIM_BUF_NIBBLE) ||
                   (dst_addr_i[31:28] != PIM_NIBBLE) ||
                   (|src_addr_i[1:0]) || (|dst_addr_i[1:0]) ||
                   crosses_window(src_addr_i[27:0], span) ||
                   crosses_window(dst_addr_i[27:0], span);

  // Occupancy after this cycle's push/pop; a new read is only issued if its return can still fit.
  assign in_xfer    = (state_q == ST_XFER);
  assign pop        = in_xfer && gnt_dma_i && (fifo_cnt != 2'd0);
  assign occ        = {1'b0, fifo_cnt} + {2'b0, ret_q} - {2'b0, pop};
  assign rd_issue   = in_xfer && gnt_dma_i && (rd_cnt_q < len_q) && (occ <= 3'(FIFO_DEPTH - 1));
  assign flush      = in_xfer && abort_i;
  assign wr_cnt_nxt = wr_cnt_q + LEN_W'(1);

  dma_fifo2 u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ret_q),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (dma_dout_0_i),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  always_comb begin
    dma_addr_0_o  = '0;
    dma_read_0_o  = 1'b0;
    dma_size_0_o  = '0;
    dma_addr_1_o  = '0;
    dma_write_1_o = 1'b0;
    dma_size_1_o  = '0;
    dma_din_1_o   = '0;
    if (rd_issue) begin
      dma_addr_0_o = src_q + 32'({rd_cnt_q, 2'b00});
      dma_read_0_o = 1'b1;
      dma_size_0_o = SIZE_WORD;
    end
    if (pop) begin
      dma_addr_1_o  = dst_q + 32'({wr_cnt_q, 2'b00});
      dma_write_1_o = 1'b1;
      dma_size_1_o  = SIZE_WORD;
      dma_din_1_o   = fifo_head;
    end
  end

  assign dma_write_0_o = 1'b0;
  assign dma_din_0_o   = '0;
  assign dma_read_1_o  = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ret_q     <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      req_dma_o <= 1'b0;
    end else begin
      ret_q <= rd_issue;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            src_q    <= src_addr_i;
            dst_q    <= dst_addr_i;
            len_q    <= len_i;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_o    <= 1'b0;
            if (len_i == '0) begin
              state_q <= ST_DONE;
              done_o  <= 1'b1;
            end else if (cfg_err) begin
              state_q <= ST_DONE;
              done_o  <= 1'b1;
              err_o   <= 1'b1;
            end else begin
              state_q   <= ST_XFER;
              busy_o    <= 1'b1;
              req_dma_o <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          if (abort_i) begin
            state_q   <= ST_DONE;
            ret_q     <= 1'b0;
            busy_o    <= 1'b0;
            req_dma_o <= 1'b0;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
          end else begin
            if (rd_issue) begin
              rd_cnt_q <= rd_cnt_q + LEN_W'(1);
            end
            if (pop) begin
              wr_cnt_q <= wr_cnt_nxt;
              if (wr_cnt_nxt == len_q) begin
                state_q   <= ST_DONE;
                busy_o    <= 1'b0;
                req_dma_o <= 1'b0;
                done_o    <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// Directed bench for pim_dma_ctrl: cycle-exact command schedules, data integrity, errors, abort, reset.
module tb_pim_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        abort;
  logic        busy, done, err, req;
  logic        gnt;
  logic [31:0] addr_0, din_0, dout_0;
  logic        read_0, write_0;
  logic [3:0]  size_0;
  logic [31:0] addr_1, din_1, dout_1;
  logic        read_1, write_1;
  logic [3:0]  size_1;

  int n_checks = 0;
  int n_errors = 0;
  int rd_q[$];
  int wr_q[$];

  always #5 clk = ~clk;

  pim_dma_ctrl #(.LEN_W(16), .FIFO_DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .src_addr_i    (src_addr),
    .dst_addr_i    (dst_addr),
    .len_i         (len),
    .abort_i       (abort),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .req_dma_o     (req),
    .gnt_dma_i     (gnt),
    .dma_addr_0_o  (addr_0),
    .dma_read_0_o  (read_0),
    .dma_write_0_o (write_0),
    .dma_size_0_o  (size_0),
    .dma_din_0_o   (din_0),
    .dma_dout_0_i  (dout_0),
    .dma_addr_1_o  (addr_1),
    .dma_read_1_o  (read_1),
    .dma_write_1_o (write_1),
    .dma_size_1_o  (size_1),
    .dma_din_1_o   (din_1),
    .dma_dout_1_i  (dout_1)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cycle 0 carries start_i; grant is low in cycles lo_a..lo_b; abort_i pulses in cycle ab_cyc.
  task automatic run(input string nm, input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] l, input int lo_a, input int lo_b, input int ab_cyc,
                     input int done_cyc, input logic xfer_ok, input logic exp_err);
    int          nrd;
    int          nwr;
    int          exp_c;
    logic        prev_rd;
    logic [31:0] prev_addr;
    logic        exp_req;
    nrd = 0;
    nwr = 0;
    prev_rd = 1'b0;
    prev_addr = '0;
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    gnt = 1'b1; abort = (ab_cyc == 0);
    for (int c = 1; c <= done_cyc + 1; c++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      gnt    = !(c >= lo_a && c <= lo_b);
      abort  = (c == ab_cyc);
      dout_0 = prev_rd ? mem_word(prev_addr) : 32'hDEAD_0000 + 32'(c);
      #4;
      prev_rd   = read_0;
      prev_addr = addr_0;
      if (read_0) begin
        exp_c = (nrd < rd_q.size()) ? rd_q[nrd] : -1;
        chk($sformatf("%s rd%0d cycle", nm, nrd), c, exp_c);
        chk($sformatf("%s rd%0d addr", nm, nrd), addr_0, s + 32'(4 * nrd));
        chk($sformatf("%s rd%0d size", nm, nrd), size_0, 4'hF);
        nrd++;
      end
      if (write_1) begin
        exp_c = (nwr < wr_q.size()) ? wr_q[nwr] : -1;
        chk($sformatf("%s wr%0d cycle", nm, nwr), c, exp_c);
        chk($sformatf("%s wr%0d addr", nm, nwr), addr_1, d + 32'(4 * nwr));
        chk($sformatf("%s wr%0d data", nm, nwr), din_1, mem_word(s + 32'(4 * nwr)));
        chk($sformatf("%s wr%0d size", nm, nwr), size_1, 4'hF);
        nwr++;
      end
      exp_req = xfer_ok && (c < done_cyc);
      chk($sformatf("%s c%0d done", nm, c), done, c == done_cyc);
      chk($sformatf("%s c%0d req", nm, c), req, exp_req);
      chk($sformatf("%s c%0d busy", nm, c), busy, exp_req);
      chk($sformatf("%s c%0d fixed0", nm, c), {write_0, read_1, din_0}, '0);
      if (c == done_cyc) chk($sformatf("%s err at done", nm), err, exp_err);
      if (c == 1 && done_cyc > 1) chk($sformatf("%s err cleared", nm), err, 1'b0);
    end
    chk($sformatf("%s read count", nm), nrd, rd_q.size());
    chk($sformatf("%s write count", nm), nwr, wr_q.size());
    gnt = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; gnt = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; dout_0 = '0; dout_1 = 32'h1234_5678;
    #12;
    chk("reset req", req, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset cmds", {read_0, write_1, addr_0, addr_1}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    rd_q = '{1, 2, 3, 4};  wr_q = '{3, 4, 5, 6};
    run("basic", 32'h2000_0000, 32'h4000_0010, 16'd4, -1, -1, -1, 7, 1'b1, 1'b0);

    rd_q = '{1, 2, 5, 6};  wr_q = '{5, 6, 7, 8};
    run("gntgap", 32'h2000_0000, 32'h4000_0010, 16'd4, 3, 4, -1, 9, 1'b1, 1'b0);

    rd_q = {};  wr_q = {};
    run("len0", 32'h2000_0000, 32'h4000_0000, 16'd0, -1, -1, -1, 1, 1'b0, 1'b0);
    run("badsrc", 32'h1000_4000, 32'h4000_0000, 16'd4, -1, -1, -1, 1, 1'b0, 1'b1);
    run("baddst", 32'h2000_0000, 32'h4000_0002, 16'd4, -1, -1, -1, 1, 1'b0, 1'b1);
    run("crossing", 32'h2FFF_FFFC, 32'h4000_0000, 16'd2, -1, -1, -1, 1, 1'b0, 1'b1);

    rd_q = '{1, 2, 3};  wr_q = '{3};
    run("abort", 32'h2000_0100, 32'h4000_0200, 16'd8, -1, -1, 3, 4, 1'b1, 1'b1);

    // Abort coincident with start in IDLE must be ignored; this start also clears err_o.
    rd_q = '{1, 2, 3};  wr_q = '{3, 4, 5};
    run("startabort", 32'h2000_0040, 32'h4FFF_FFF4, 16'd3, -1, -1, 0, 6, 1'b1, 1'b0);

    @(posedge clk); #1;
    start = 1'b1; src_addr = 32'h2000_0000; dst_addr = 32'h4000_0000; len = 16'd8; gnt = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre-reset req", req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async reset req", req, 1'b0);
    chk("async reset busy", busy, 1'b0);
    chk("async reset cmds", {read_0, write_1, size_0, size_1, addr_0, addr_1, din_1}, '0);
    @(posedge clk); #1 rst_n = 1'b1; gnt = 1'b0;

    rd_q = '{1, 2, 3, 4};  wr_q = '{3, 4, 5, 6};
    run("postreset", 32'h2000_1000, 32'h4000_2000, 16'd4, -1, -1, -1, 7, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
